// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - registered next-PC selection with stall, JALR bit-0 clear and misaligned-target trap
module pc_next_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              IALIGN       = 4,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             jump,
    input  logic             jalr_enable,
    input  logic             branch,
    input  logic             zero,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             redirect,
    output logic             trap_valid,
    output logic [XLEN-1:0]  trap_epc,
    output logic [XLEN-1:0]  trap_tval,
    output logic [CNT_W-1:0] upd_count
);

    // Low address bits that must be zero for a legal instruction target.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    typedef enum logic {RUN, TRAP} state_t;

    state_t            state;
    state_t            state_next;
    logic [XLEN-1:0]   tgt;
    logic [XLEN-1:0]   jalr_sum;
    logic [XLEN-1:0]   pc_rel;
    logic              misaligned;
    logic [XLEN-1:0]   pc_next;
    logic [XLEN-1:0]   epc_next;
    logic [XLEN-1:0]   tval_next;
    logic [CNT_W-1:0]  cnt_next;

    assign pc_plus4   = pc + XLEN'(4);
    assign trap_valid = (state == TRAP);

    // Priority target select: JALR, then JAL, then taken branch, then sequential.
    always_comb begin
        jalr_sum   = rs1_data + imm;
        pc_rel     = pc + imm;
        tgt        = pc_plus4;
        redirect   = 1'b0;
        if (jump && jalr_enable) begin
            tgt = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (jump || (branch && zero)) begin
            tgt = pc_rel;
        end
        if ((state == RUN) && !stall && (jump || (branch && zero))) begin
            redirect = 1'b1;
        end
        // Sequential fetch is never checked; only redirected targets can fault.
        misaligned = redirect && ((tgt & ALIGN_MASK) != '0);
    end

    // Next-state and next-register values; everything holds unless RUN advances or traps.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        epc_next   = trap_epc;
        tval_next  = trap_tval;
        cnt_next   = upd_count;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (misaligned) begin
                        state_next = TRAP;
                        pc_next    = TRAP_VECTOR;
                        epc_next   = pc;
                        tval_next  = tgt;
                    end else begin
                        pc_next  = tgt;
                        cnt_next = upd_count + CNT_W'(1);
                    end
                end
            end
            TRAP: begin
                // One-cycle trap announcement; stall and control inputs are ignored.
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // State register with synchronous active-low reset that overrides stall and TRAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            pc        <= RESET_VECTOR;
            trap_epc  <= '0;
            trap_tval <= '0;
            upd_count <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            trap_epc  <= epc_next;
            trap_tval <= tval_next;
            upd_count <= cnt_next;
        end
    end

endmodule
